// File: rtl/axi_rdata_arbiter.sv
// R-channel arbiter: round-robin over S0/S1/DS, burst-locked grant, routes beats to M0/M1 by RID[7:4].
// Latency: one arbitration cycle in IDLE, then beats pass combinationally (valid/ready) while the grant is held.
// Backpressure: selected slave ready follows the destination master ready; undecodable IDs are drained at full rate.
module axi_rdata_arbiter #(
   parameter int ID_W      = 8,
   parameter int MAX_BEATS = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            S0_RValid,
   input  logic            S0_RLast,
   input  logic [ID_W-1:0] S0_RID,
   output logic            S0_RReady,
   input  logic            S1_RValid,
   input  logic            S1_RLast,
   input  logic [ID_W-1:0] S1_RID,
   output logic            S1_RReady,
   input  logic            DS_RValid,
   input  logic            DS_RLast,
   input  logic [ID_W-1:0] DS_RID,
   output logic            DS_RReady,
   input  logic            M0_RReady,
   output logic            M0_RValid,
   input  logic            M1_RReady,
   output logic            M1_RValid,
   output logic [2:0]      slave_sel,
   output logic [1:0]      master_sel,
   output logic [7:0]      beat_cnt,
   output logic            err_dec,
   output logic            err_len
);

   typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, DRAIN = 2'd2} state_t;

   state_t     state;
   logic [1:0] rr_ptr;
   logic [1:0] sel_idx;
   logic [1:0] grant_idx;
   logic       grant_any;
   logic [2:0] cand;
   logic [3:0] grant_field;
   logic [2:0] s_vld;
   logic [2:0] s_last;
   logic [2:0] s_rdy;
   logic       m_rdy;
   logic       sel_vld;
   logic       sel_last;
   logic       hs;
   logic       unused_rid;

   assign s_vld      = {DS_RValid, S1_RValid, S0_RValid};
   assign s_last     = {DS_RLast, S1_RLast, S0_RLast};
   assign unused_rid = ^{S0_RID, S1_RID, DS_RID};

   // Walk the rotation backwards so the candidate closest to rr_ptr wins.
   always_comb begin
      grant_idx = rr_ptr;
      grant_any = 1'b0;
      cand      = 3'd0;
      for (int i = 2; i >= 0; i--) begin
         cand = {1'b0, rr_ptr} + 3'(i);
         if (cand > 3'd2) cand = cand - 3'd3;
         if (s_vld[cand[1:0]]) begin
            grant_idx = cand[1:0];
            grant_any = 1'b1;
         end
      end
   end

   always_comb begin
      case (grant_idx)
         2'd0:    grant_field = S0_RID[7:4];
         2'd1:    grant_field = S1_RID[7:4];
         default: grant_field = DS_RID[7:4];
      endcase
   end

   assign m_rdy    = (master_sel[0] & M0_RReady) | (master_sel[1] & M1_RReady);
   assign sel_vld  = |(s_vld & slave_sel);
   assign sel_last = |(s_last & slave_sel);

   always_comb begin
      s_rdy     = 3'b000;
      M0_RValid = 1'b0;
      M1_RValid = 1'b0;
      case (state)
         BURST: begin
            s_rdy     = slave_sel & {3{m_rdy}};
            M0_RValid = master_sel[0] & sel_vld;
            M1_RValid = master_sel[1] & sel_vld;
         end
         DRAIN:   s_rdy = slave_sel;
         default: ;
      endcase
   end

   assign {DS_RReady, S1_RReady, S0_RReady} = s_rdy;
   assign hs = |(s_vld & s_rdy);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         rr_ptr     <= 2'd0;
         sel_idx    <= 2'd0;
         slave_sel  <= 3'b000;
         master_sel <= 2'b00;
         beat_cnt   <= 8'd0;
         err_dec    <= 1'b0;
         err_len    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  slave_sel <= 3'b001 << grant_idx;
                  sel_idx   <= grant_idx;
                  beat_cnt  <= 8'd0;
                  case (grant_field)
                     4'b0001: begin
                        master_sel <= 2'b01;
                        state      <= BURST;
                     end
                     4'b0010: begin
                        master_sel <= 2'b10;
                        state      <= BURST;
                     end
                     default: begin
                        master_sel <= 2'b00;
                        err_dec    <= 1'b1;
                        state      <= DRAIN;
                     end
                  endcase
               end
            end
            BURST, DRAIN: begin
               if (hs) begin
                  if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
                  if (MAX_BEATS < 255 && int'(beat_cnt) == MAX_BEATS) err_len <= 1'b1;
                  if (sel_last) begin
                     state      <= IDLE;
                     slave_sel  <= 3'b000;
                     master_sel <= 2'b00;
                     rr_ptr     <= (sel_idx == 2'd2) ? 2'd0 : sel_idx + 2'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_rdata_arbiter.sv
// Bench for axi_rdata_arbiter: directed scenarios plus randomized slave/master traffic,
// checked every cycle against a transaction-level round-robin model.
module tb_axi_rdata_arbiter;

   localparam int MAXB = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       S0_RValid, S0_RLast, S0_RReady;
   logic [7:0] S0_RID;
   logic       S1_RValid, S1_RLast, S1_RReady;
   logic [7:0] S1_RID;
   logic       DS_RValid, DS_RLast, DS_RReady;
   logic [7:0] DS_RID;
   logic       M0_RReady, M0_RValid, M1_RReady, M1_RValid;
   logic [2:0] slave_sel;
   logic [1:0] master_sel;
   logic [7:0] beat_cnt;
   logic       err_dec, err_len;

   axi_rdata_arbiter #(.ID_W(8), .MAX_BEATS(MAXB)) dut (
      .clk(clk), .rst(rst),
      .S0_RValid(S0_RValid), .S0_RLast(S0_RLast), .S0_RID(S0_RID), .S0_RReady(S0_RReady),
      .S1_RValid(S1_RValid), .S1_RLast(S1_RLast), .S1_RID(S1_RID), .S1_RReady(S1_RReady),
      .DS_RValid(DS_RValid), .DS_RLast(DS_RLast), .DS_RID(DS_RID), .DS_RReady(DS_RReady),
      .M0_RReady(M0_RReady), .M0_RValid(M0_RValid),
      .M1_RReady(M1_RReady), .M1_RValid(M1_RValid),
      .slave_sel(slave_sel), .master_sel(master_sel), .beat_cnt(beat_cnt),
      .err_dec(err_dec), .err_len(err_len)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // slave drivers
   bit         act [3];
   int         blen [3];
   int         bbeat [3];
   logic [7:0] brid [3];
   bit         hs_s [3];
   bit         rand_en = 1'b0;
   bit         tog_m1 = 1'b0;

   // reference model
   bit  e_busy, e_new;
   int  e_g, e_dest, e_cnt, rr;
   bit  e_err_dec, e_err_len;
   int  hs_cnt [3];
   int  rdy_cyc [3];
   int  mvld_cyc [2];
   int  grant_log [$];

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      logic [19:0] outs;
      outs = {slave_sel, master_sel, beat_cnt, err_dec, err_len,
              S0_RReady, S1_RReady, DS_RReady, M0_RValid, M1_RValid};
      check(tag, int'(outs), 0);
   endtask

   task automatic model_reset();
      e_busy = 0; e_new = 0; e_g = 0; e_dest = 0; e_cnt = 0; rr = 0;
      e_err_dec = 0; e_err_len = 0;
   endtask

   task automatic apply();
      logic [2:0] v, l;
      logic [7:0] r [3];
      for (int s = 0; s < 3; s++) begin
         v[s] = act[s] && !(rand_en && ($urandom % 8 == 0));
         l[s] = act[s] && (bbeat[s] == blen[s] - 1);
         r[s] = (rand_en && ($urandom % 4 == 0)) ? 8'($urandom) : brid[s];
      end
      S0_RValid = v[0]; S0_RLast = l[0]; S0_RID = r[0];
      S1_RValid = v[1]; S1_RLast = l[1]; S1_RID = r[1];
      DS_RValid = v[2]; DS_RLast = l[2]; DS_RID = r[2];
   endtask

   task automatic drv_reset();
      for (int s = 0; s < 3; s++) begin
         act[s] = 0; blen[s] = 1; bbeat[s] = 0; brid[s] = 8'h00; hs_s[s] = 0;
      end
      apply();
   endtask

   task automatic load(input int s, input int len, input logic [7:0] id);
      act[s] = 1; blen[s] = len; bbeat[s] = 0; brid[s] = id;
      apply();
   endtask

   task automatic drive_step();
      int r;
      for (int s = 0; s < 3; s++) begin
         if (act[s] && hs_s[s]) begin
            bbeat[s]++;
            if (bbeat[s] == blen[s]) act[s] = 0;
         end
         if (rand_en && !act[s] && ($urandom % 3 == 0)) begin
            r = $urandom % 8;
            act[s] = 1; bbeat[s] = 0; blen[s] = 1 + $urandom % 6;
            brid[s] = {(r < 3) ? 4'h1 : (r < 6) ? 4'h2 : (r == 6) ? 4'h0 : 4'hF, 4'($urandom)};
         end
      end
      if (rand_en) begin
         M0_RReady = ($urandom % 4 != 0);
         M1_RReady = ($urandom % 3 != 0);
      end else if (tog_m1) begin
         M1_RReady = ~M1_RReady;
      end
      apply();
   endtask

   // Expected behaviour at the bus level: who should be granted, where beats go, what the counters read.
   task automatic model_step();
      logic [2:0] vld, lst, rdy;
      logic [1:0] mrdy, mvld;
      logic [7:0] rid [3];
      int g, s2, field;
      bit exp_rdy;
      vld = {DS_RValid, S1_RValid, S0_RValid};
      lst = {DS_RLast, S1_RLast, S0_RLast};
      rdy = {DS_RReady, S1_RReady, S0_RReady};
      mrdy = {M1_RReady, M0_RReady};
      mvld = {M1_RValid, M0_RValid};
      rid[0] = S0_RID; rid[1] = S1_RID; rid[2] = DS_RID;
      for (int s = 0; s < 3; s++) begin
         hs_s[s] = vld[s] & rdy[s];
         if (hs_s[s]) hs_cnt[s]++;
         if (rdy[s]) rdy_cyc[s]++;
      end
      for (int m = 0; m < 2; m++) if (mvld[m]) mvld_cyc[m]++;
      check("err_dec", int'(err_dec), int'(e_err_dec));
      check("err_len", int'(err_len), int'(e_err_len));
      check("beat_cnt", int'(beat_cnt), e_cnt);
      if (!e_busy) begin
         check("idle_slave_sel", int'(slave_sel), 0);
         check("idle_master_sel", int'(master_sel), 0);
         check("idle_s_rready", int'(rdy), 0);
         check("idle_m_rvalid", int'(mvld), 0);
         g = -1;
         for (int k = 0; k < 3; k++) begin
            s2 = (rr + k) % 3;
            if (g < 0 && vld[s2]) g = s2;
         end
         if (g >= 0) begin
            field = int'(rid[g][7:4]);
            e_dest = (field == 1) ? 0 : (field == 2) ? 1 : -1;
            if (e_dest < 0) e_err_dec = 1;
            e_g = g; e_busy = 1; e_new = 1; e_cnt = 0;
         end
      end else begin
         check("slave_sel", int'(slave_sel), 1 << e_g);
         check("master_sel", int'(master_sel), (e_dest < 0) ? 0 : (1 << e_dest));
         if (e_new) grant_log.push_back(int'(slave_sel));
         e_new = 0;
         exp_rdy = (e_dest < 0) ? 1'b1 : mrdy[e_dest];
         check("s_rready", int'(rdy), exp_rdy ? (1 << e_g) : 0);
         check("m_rvalid", int'(mvld), (e_dest >= 0 && vld[e_g]) ? (1 << e_dest) : 0);
         if (vld[e_g] && exp_rdy) begin
            if (e_cnt < 255) e_cnt++;
            if (e_cnt == MAXB + 1) e_err_len = 1;
            if (lst[e_g]) begin
               e_busy = 0;
               rr = (e_g + 1) % 3;
            end
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      drive_step();
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while ((e_busy || act[0] || act[1] || act[2]) && n < budget) begin
         cycle();
         n++;
      end
      check(tag, int'(e_busy || act[0] || act[1] || act[2]), 0);
   endtask

   task automatic clr_stats();
      for (int s = 0; s < 3; s++) begin hs_cnt[s] = 0; rdy_cyc[s] = 0; end
      mvld_cyc[0] = 0; mvld_cyc[1] = 0;
   endtask

   initial begin
      int n;
      bit reload;
      rst = 1'b0;
      M0_RReady = 1'b0; M1_RReady = 1'b0;
      model_reset();
      drv_reset();
      clr_stats();
      #12;
      check_zero("reset_outputs");
      @(posedge clk); #1;
      rst = 1'b1;

      // single 4-beat burst S0 -> M0
      M0_RReady = 1'b1;
      clr_stats();
      load(0, 4, 8'h15);
      wait_idle("t1_timeout", 40);
      check("t1_beat_cnt", int'(beat_cnt), 4);
      check("t1_s0_ready_cycles", rdy_cyc[0], 4);
      cycle();
      check("t1_cnt_hold", int'(beat_cnt), 4);

      // S1 -> M1 with toggling master ready
      M0_RReady = 1'b0; M1_RReady = 1'b1; tog_m1 = 1'b1;
      clr_stats();
      load(1, 2, 8'h23);
      wait_idle("t3_timeout", 40);
      tog_m1 = 1'b0;
      check("t3_beat_cnt", int'(beat_cnt), 2);
      check("t3_m0_valid_cycles", mvld_cyc[0], 0);
      check("t3_s1_handshakes", hs_cnt[1], 2);

      // undecodable ID drained from DS
      M0_RReady = 1'b1; M1_RReady = 1'b1;
      clr_stats();
      load(2, 3, 8'h40);
      wait_idle("t4_timeout", 40);
      check("t4_beat_cnt", int'(beat_cnt), 3);
      check("t4_ds_ready_cycles", rdy_cyc[2], 3);
      check("t4_m_valid_cycles", mvld_cyc[0] + mvld_cyc[1], 0);
      repeat (5) cycle();
      check("t4_err_dec_sticky", int'(err_dec), 1);

      // round-robin with all three requesting
      grant_log.delete();
      load(0, 1, 8'h15); load(1, 1, 8'h25); load(2, 1, 8'h16);
      reload = 1'b1;
      n = 0;
      while ((grant_log.size() < 4 || e_busy || act[0] || act[1] || act[2]) && n < 60) begin
         cycle();
         if (reload && !act[0]) begin
            load(0, 1, 8'h18);
            reload = 1'b0;
         end
         n++;
      end
      check("t2_grant_count", grant_log.size(), 4);
      if (grant_log.size() >= 4) begin
         check("t2_grant0", grant_log[0], 1);
         check("t2_grant1", grant_log[1], 2);
         check("t2_grant2", grant_log[2], 4);
         check("t2_grant3", grant_log[3], 1);
      end

      // over-long burst
      load(0, 18, 8'h11);
      wait_idle("t5_timeout", 80);
      check("t5_err_len", int'(err_len), 1);
      check("t5_beat_cnt", int'(beat_cnt), 18);

      // reset in the middle of a burst
      clr_stats();
      load(0, 4, 8'h12);
      n = 0;
      while (hs_cnt[0] < 2 && n < 20) begin
         cycle();
         n++;
      end
      check("t6_two_beats", hs_cnt[0], 2);
      rst = 1'b0;
      #1;
      check_zero("t6_async_reset");
      model_reset();
      drv_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      grant_log.delete();
      load(1, 2, 8'h21);
      wait_idle("t6_timeout", 40);
      check("t6_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 2);

      // randomized traffic
      rand_en = 1'b1;
      repeat (3000) cycle();
      rand_en = 1'b0;
      M0_RReady = 1'b1; M1_RReady = 1'b1;
      wait_idle("rnd_timeout", 200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/axi_rdata_arbiter.md
Name: axi_rdata_arbiter

Overview:
- Controller for the AXI read-data (R) channel crossbar between three slave sources (S0, S1, default slave DS) and two masters (M0, M1).
- Arbitrates among slaves with valid read data using round-robin.
- Locks the grant for a whole burst, until the RLast handshake.
- Routes each burst to the master encoded in RID[7:4], and drives the R-channel valid/ready handshakes and the data-mux select.
- Beats carrying an undecodable master ID are drained so the bus cannot deadlock.

Parameters:
- ID_W, 8, RID width; the master field is RID[7:4].
- MAX_BEATS, 16, longest legal burst length; exceeding it raises err_len.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- S0_RValid  in  1  slave 0 read-data valid
- S0_RLast  in  1  slave 0 last beat
- S0_RID  in  ID_W  slave 0 read ID
- S0_RReady  out  1  ready to slave 0
- S1_RValid, S1_RLast, S1_RID, S1_RReady  as for S0
- DS_RValid, DS_RLast, DS_RID, DS_RReady  as for S0
- M0_RReady  in  1  master 0 ready
- M0_RValid  out  1  master 0 valid
- M1_RReady  in  1  master 1 ready
- M1_RValid  out  1  master 1 valid
- slave_sel  out  3  one-hot data-mux select {DS,S1,S0}; 000 = none
- master_sel  out  2  one-hot destination {M1,M0}; 00 = none or drain
- beat_cnt  out  8  handshaked beats in the current or last burst, saturating at 255
- err_dec  out  1  sticky: a burst had a master field not equal to 4'b0001 or 4'b0010
- err_len  out  1  sticky: beat_cnt exceeded MAX_BEATS

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr_ptr=S0.
  - slave_sel=000, master_sel=00, beat_cnt=0, err_dec=0, err_len=0.
  - All S*_RReady=0 and M*_RValid=0.
- States: IDLE, BURST, DRAIN.
- IDLE:
  - All ready and valid outputs are 0.
  - If any S*_RValid=1, pick the first valid slave in rotation order starting at rr_ptr (order S0→S1→DS→S0).
  - Register slave_sel (one-hot), capture that slave's RID[7:4], and clear beat_cnt.
  - Field 4'b0001: master_sel=01, go to BURST. Field 4'b0010: master_sel=10, go to BURST.
  - Any other field: master_sel=00, set err_dec, go to DRAIN.
  - Arbitration latency is 1 cycle: the first beat can handshake in the cycle after valid is first seen.
- BURST:
  - Selected M*_RValid = selected S*_RValid.
  - Selected S*_RReady = selected M*_RReady.
  - Every unselected S*_RReady=0 and the other M*_RValid=0.
  - Handshake = selected S*_RValid & selected M*_RReady; each handshake increments beat_cnt.
- DRAIN:
  - Selected S*_RReady=1 and both M*_RValid=0.
  - Each accepted beat increments beat_cnt.
- End of burst (BURST or DRAIN):
  - On a handshake with RLast=1: go to IDLE; slave_sel and master_sel clear to 0 in the next cycle.
  - rr_ptr moves to the slave after the one just granted.
  - beat_cnt holds its value until the next grant.
- Grant lock: while in BURST or DRAIN, a change in another slave's RValid or in the selected RID has no effect; the destination stays the one captured at grant.
- Selected valid dropping mid-burst (protocol violation): no handshake that cycle, state is held, no timeout.
- err_len: set when a handshake makes beat_cnt equal to MAX_BEATS+1. The burst still runs to RLast.
- beat_cnt saturates at 255. err_dec and err_len clear only on reset.
- Back-to-back bursts: at least one IDLE cycle between bursts (the arbitration cycle).
- Reset mid-burst: everything returns to reset values at once, and the in-flight burst is abandoned.

Test Plan:
- Reset release, S0_RValid=1, S0_RID=8'h15, M0_RReady=1, 4 beats with RLast on beat 4 → slave_sel=001 and master_sel=01 from cycle 2; S0_RReady=1 for 4 cycles; beat_cnt=4; back to IDLE; rr_ptr=S1.
- S0, S1 and DS all valid from IDLE with rr_ptr=S0 and single-beat bursts → grant order S0, S1, DS, S0, each grant separated by one IDLE cycle.
- S1 burst to M1 (RID=8'h23) with M1_RReady toggling 1,0,1,0 over a 2-beat burst → S1_RReady tracks M1_RReady exactly; M0_RValid=0 throughout; beat_cnt=2.
- DS_RID=8'h40, 3-beat burst → master_sel=00, DS_RReady=1 for 3 cycles, M0_RValid=M1_RValid=0, err_dec=1 and stays 1.
- S0 burst to M0 of 18 beats → err_len=1 after beat 17; burst completes on RLast; beat_cnt=18.
- rst asserted mid-burst after 2 of 4 beats → outputs zero immediately; after release, a new S1 request is granted first because rr_ptr=S0 and S0 is idle.
